// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and helpers for the pipelined add/subtract unit
// Purpose: mode encodings for i_sub, segment width helper and the legal
//          STAGES/DATA_W check used at elaboration by pipe_adder.
// Ports:   none (package).
package adder_pkg;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_SUB = 1'b1;

   localparam int STAGES_MIN = 1;
   localparam int STAGES_MAX = 8;

   function automatic int seg_w(input int data_w, input int stages);
      return data_w / stages;
   endfunction

   // Range is tested first so the modulo never sees a zero divisor.
   function automatic bit stages_ok(input int data_w, input int stages);
      if ((stages < STAGES_MIN) || (stages > STAGES_MAX) || (data_w <= 0)) begin
         return 1'b0;
      end
      return (data_w % stages) == 0;
   endfunction

endpackage

// File: rtl/adder_seg.sv
// rtl/adder_seg.sv - combinational SEG_W-bit adder segment with carry chain ports
// Purpose: one carry-chained slice of the pipelined adder.
// Ports:   a, b   - segment operands (b already inverted for subtract)
//          cin    - carry into the segment
//          sum    - segment sum
//          cout   - carry out of the segment MSB
//          a_msb, b_msb - operand MSBs, used by the top segment for overflow
module adder_seg #(
   parameter int SEG_W = 32
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             cin,
   output logic [SEG_W-1:0] sum,
   output logic             cout,
   output logic             a_msb,
   output logic             b_msb
);

   always_comb begin
      {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
      a_msb       = a[SEG_W-1];
      b_msb       = b[SEG_W-1];
   end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined DATA_W-bit add/subtract unit split into STAGES segments
// Purpose: stage k adds segment k using the carry registered by stage k-1. Operand
//          segments not yet consumed ride along in skew registers; finished sum
//          segments ride along in the same accumulator, so the result leaves aligned.
// Ports:   i_clk, i_rst_n (async, active-low)
//          i_valid, i_sub, i_data0, i_data1 - operation request
//          i_stall - hold every register; i_flush - drop all in-flight ops
//          o_valid, o_data, o_carry, o_ovf - result, latency STAGES
module pipe_adder
   import adder_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   input  logic              i_sub,
   input  logic [DATA_W-1:0] i_data0,
   input  logic [DATA_W-1:0] i_data1,
   input  logic              i_stall,
   input  logic              i_flush,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_carry,
   output logic              o_ovf
);

   localparam int SEG_W = seg_w(DATA_W, STAGES);
   // Skew storage only exists between stages; sizes are clamped so STAGES=1 still elaborates.
   localparam int BW    = (STAGES > 1) ? DATA_W - SEG_W : 1;
   localparam int NB    = (STAGES > 1) ? STAGES - 1 : 1;

   if (!stages_ok(DATA_W, STAGES)) begin : g_bad_params
      $error("pipe_adder: STAGES must be 1..8 and divide DATA_W");
   end

   logic [DATA_W-1:0] b_eff;
   logic              c_in;

   // acc_q[k]: sum segments 0..k in the low bits, untouched A segments above them.
   logic [DATA_W-1:0] acc_q [STAGES];
   // bsh_q[k]: B' segments k+1.. shifted down so the next segment is always at bit 0.
   logic [BW-1:0]     bsh_q [NB];
   logic [STAGES-1:0] cy_q;
   logic [STAGES-1:0] vld_q;
   logic              ovf_q;

   always_comb begin
      b_eff = (i_sub == ALU_ADD) ? i_data1 : ~i_data1;
      c_in  = (i_sub == ALU_SUB);
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SEG_W-1:0]  seg_a;
      logic [SEG_W-1:0]  seg_b;
      logic [SEG_W-1:0]  seg_sum;
      logic              seg_cin;
      logic              seg_cout;
      logic              v_in;
      logic              ld;
      logic              vld_d;
      logic              cy_d;
      logic [DATA_W-1:0] acc_d;

      if (k == 0) begin : g_first
         always_comb begin
            seg_a   = i_data0[SEG_W-1:0];
            seg_b   = b_eff[SEG_W-1:0];
            seg_cin = c_in;
            v_in    = i_valid;
         end
         always_comb begin
            acc_d            = i_data0;
            acc_d[SEG_W-1:0] = seg_sum;
         end
      end else begin : g_next
         always_comb begin
            seg_a   = acc_q[k-1][k*SEG_W +: SEG_W];
            seg_b   = bsh_q[k-1][SEG_W-1:0];
            seg_cin = cy_q[k-1];
            v_in    = vld_q[k-1];
         end
         always_comb begin
            acc_d                   = acc_q[k-1];
            acc_d[k*SEG_W +: SEG_W] = seg_sum;
         end
      end

      // Data only moves with a live op, so outputs keep the last result while idle.
      always_comb begin
         ld   = v_in && !i_stall && !i_flush;
         cy_d = seg_cout;
         if (i_flush) begin
            vld_d = 1'b0;
         end else if (i_stall) begin
            vld_d = vld_q[k];
         end else begin
            vld_d = v_in;
         end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            vld_q[k] <= 1'b0;
            acc_q[k] <= '0;
            cy_q[k]  <= 1'b0;
         end else begin
            vld_q[k] <= vld_d;
            if (ld) begin
               acc_q[k] <= acc_d;
               cy_q[k]  <= cy_d;
            end
         end
      end

      if (k < STAGES - 1) begin : g_skew
         logic [BW-1:0] bsh_d;
         if (k == 0) begin : g_skew_first
            always_comb bsh_d = b_eff[DATA_W-1:SEG_W];
         end else begin : g_skew_next
            always_comb bsh_d = bsh_q[k-1] >> SEG_W;
         end
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               bsh_q[k] <= '0;
            end else if (ld) begin
               bsh_q[k] <= bsh_d;
            end
         end
      end

      if (k == STAGES - 1) begin : g_top_seg
         logic top_a_msb;
         logic top_b_msb;
         logic ovf_d;

         adder_seg #(.SEG_W(SEG_W)) u_seg (
            .a     (seg_a),
            .b     (seg_b),
            .cin   (seg_cin),
            .sum   (seg_sum),
            .cout  (seg_cout),
            .a_msb (top_a_msb),
            .b_msb (top_b_msb)
         );

         always_comb ovf_d = (top_a_msb == top_b_msb) && (seg_sum[SEG_W-1] != top_a_msb);

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               ovf_q <= 1'b0;
            end else if (ld) begin
               ovf_q <= ovf_d;
            end
         end
      end else begin : g_low_seg
         // Lower segments never feed the overflow flag.
         logic a_msb_unused;
         logic b_msb_unused;

         adder_seg #(.SEG_W(SEG_W)) u_seg (
            .a     (seg_a),
            .b     (seg_b),
            .cin   (seg_cin),
            .sum   (seg_sum),
            .cout  (seg_cout),
            .a_msb (a_msb_unused),
            .b_msb (b_msb_unused)
         );
      end
   end

   always_comb begin
      o_valid = vld_q[STAGES-1];
      o_data  = acc_q[STAGES-1];
      o_carry = cy_q[STAGES-1];
      o_ovf   = ovf_q;
   end

endmodule
